// File: rtl/fg_mask_streamer.sv
// Ping-pong line buffer turning raster-order 1-bit mask words into a per-pixel foreground stream.
// foregnd_px lags vid_hpos by one cycle; mask_ready drops when the fill bank is full or during a swap.
module fg_mask_streamer #(
  parameter int H_IMG_RES = 640,
  parameter int V_IMG_RES = 480,
  parameter int WORD_W    = 32
) (
  input  logic              app_clk,
  input  logic              app_rst_n,
  input  logic              vid_preload_line,
  input  logic              vid_active_pix,
  input  logic [10:0]       vid_hpos,
  input  logic [10:0]       vid_vpos,
  input  logic [WORD_W-1:0] mask_word,
  input  logic              mask_sof,
  input  logic              mask_valid,
  output logic              mask_ready,
  output logic              foregnd_px,
  output logic              underrun,
  output logic              sync_err
);
  localparam int WPL    = H_IMG_RES / WORD_W;
  localparam int SH     = $clog2(WORD_W);
  localparam int IDX_W  = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int CNT_W  = $clog2(WPL + 1);
  localparam int LINE_W = (V_IMG_RES > 1) ? $clog2(V_IMG_RES) : 1;

  localparam logic [CNT_W-1:0]  WPL_C     = CNT_W'(WPL);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(V_IMG_RES - 1);
  localparam logic [10:0]       H_LIM     = 11'(H_IMG_RES);
  localparam logic [10:0]       V_LIM     = 11'(V_IMG_RES);

  logic [WORD_W-1:0] line_mem [2][WPL];
  logic              fill_bank;
  logic [CNT_W-1:0]  fill_cnt;
  logic [LINE_W-1:0] fill_line;
  logic              disp_valid;

  logic              accept;
  logic              frame_idle;
  logic              do_store;
  logic              bad_sync;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [SH-1:0]     rd_bit;
  logic [WORD_W-1:0] rd_word;
  logic              pix_in_range;

  always_comb begin
    mask_ready = (fill_cnt < WPL_C) && !vid_preload_line;
    accept     = mask_valid && mask_ready;
    frame_idle = (fill_cnt == '0) && (fill_line == '0);
    // A SOF word is only legal at the idle frame start, and the idle frame start only accepts SOF.
    bad_sync   = accept && (mask_sof != frame_idle);
    do_store   = accept && (mask_sof || !frame_idle);
    wr_idx     = mask_sof ? '0 : IDX_W'(fill_cnt);
  end

  always_comb begin
    rd_idx       = IDX_W'(vid_hpos >> SH);
    rd_bit       = vid_hpos[SH-1:0];
    rd_word      = line_mem[~fill_bank][rd_idx];
    pix_in_range = vid_active_pix && (vid_hpos < H_LIM) && (vid_vpos < V_LIM) && disp_valid;
  end

  // Storage is not reset: disp_valid gates everything read out of it.
  always_ff @(posedge app_clk) begin
    if (do_store) begin
      line_mem[fill_bank][wr_idx] <= mask_word;
    end
  end

  always_ff @(posedge app_clk or negedge app_rst_n) begin
    if (!app_rst_n) begin
      fill_bank  <= 1'b0;
      fill_cnt   <= '0;
      fill_line  <= '0;
      disp_valid <= 1'b0;
      foregnd_px <= 1'b0;
      underrun   <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      sync_err   <= bad_sync;
      underrun   <= vid_preload_line && (fill_cnt != WPL_C);
      foregnd_px <= pix_in_range && rd_word[rd_bit];
      if (vid_preload_line) begin
        disp_valid <= (fill_cnt == WPL_C);
        fill_bank  <= ~fill_bank;
        fill_cnt   <= '0;
        // Advances even on underrun; a slipped source is realigned by its next SOF.
        fill_line  <= (fill_line == LAST_LINE) ? '0 : fill_line + LINE_W'(1);
      end else if (do_store) begin
        if (mask_sof) begin
          fill_cnt  <= CNT_W'(1);
          fill_line <= '0;
        end else begin
          fill_cnt  <= fill_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/fg_mask_streamer.md
Name: fg_mask_streamer

Overview:
- Producer-side counterpart of the blob analyzer's foreground input.
- Accepts packed 1-bit foreground mask words in raster order from the segmentation/memory side over a valid/ready stream.
- Buffers the words per line in a ping-pong line buffer.
- Emits `foregnd_px` aligned to the video timing (`vid_hpos`/`vid_vpos`/`vid_active_pix`), with one-cycle latency, on `app_clk`.

Parameters:
- H_IMG_RES, 640, active pixels per line.
- V_IMG_RES, 480, active lines per frame.
- WORD_W, 32, mask bits per input word; must be a power of 2 and divide H_IMG_RES.
- Derived localparam WPL = H_IMG_RES/WORD_W (default 20), the number of words per line.

Ports:
- app_clk  in  1  system/video clock; all logic is on its rising edge.
- app_rst_n  in  1  asynchronous, active-low reset.
- vid_preload_line  in  1  one-cycle pulse in horizontal blanking before each displayed line; triggers the bank swap.
- vid_active_pix  in  1  high during active video.
- vid_hpos  in  11  horizontal pixel counter.
- vid_vpos  in  11  vertical line counter.
- mask_word  in  WORD_W  mask bits; bit 0 is the leftmost pixel.
- mask_sof  in  1  marks the first word of a frame (line 0, word 0).
- mask_valid  in  1  word present.
- mask_ready  out  1  word accepted when mask_valid && mask_ready.
- foregnd_px  out  1  foreground pixel, registered.
- underrun  out  1  one-cycle pulse: swap occurred with an incomplete fill bank.
- sync_err  out  1  one-cycle pulse: SOF misalignment detected.

Behaviour:
- **Storage:**
  - Two banks, each WPL x WORD_W.
  - State registers: fill_bank (1b), disp_bank = ~fill_bank, fill_cnt (0..WPL), fill_line (0..V_IMG_RES-1), disp_valid (1b).
- **Reset:**
  - fill_bank=0, fill_cnt=0, fill_line=0, disp_valid=0.
  - Outputs foregnd_px=0, underrun=0, sync_err=0.
  - mask_ready follows its combinational equation; it is 1 after reset unless vid_preload_line is high.
  - Reset mid-line discards all buffered data.
- **mask_ready:** combinational, = (fill_cnt < WPL) && !vid_preload_line. The swap takes priority, so no word is accepted in a swap cycle.
- **Accept rules** (on mask_valid && mask_ready):
  - mask_sof=1, fill_cnt==0, fill_line==0: store the word at index 0; fill_cnt=1.
  - mask_sof=1, otherwise (fill_cnt!=0 or fill_line!=0): resync.
    - Pulse sync_err.
    - Store the word at index 0 of fill_bank.
    - fill_cnt=1, fill_line=0.
  - mask_sof=0, fill_cnt==0, fill_line==0: the frame start is missing.
    - Pulse sync_err.
    - Discard the word; state is unchanged.
  - mask_sof=0, otherwise: store the word at index fill_cnt; fill_cnt+1.
- **Swap** (vid_preload_line=1):
  - disp_valid <= (fill_cnt==WPL).
  - If fill_cnt<WPL, pulse underrun and discard the partial words.
  - fill_bank toggles; fill_cnt <= 0.
  - fill_line <= (fill_line==V_IMG_RES-1) ? 0 : fill_line+1. It increments even on underrun; a misalignment is corrected at the next SOF.
- **Full bank:** with fill_cnt==WPL, mask_ready=0 until the next swap. This is the normal backpressure path.
- **Output** (registered, latency 1 cycle from vid_hpos/vid_active_pix):
  - foregnd_px <= vid_active_pix && vid_hpos<H_IMG_RES && vid_vpos<V_IMG_RES && disp_valid ? disp_bank[vid_hpos/WORD_W][vid_hpos%WORD_W] : 0.
- **Pulses:**
  - underrun and sync_err are registered and high for exactly one cycle per event.
  - A simultaneous swap and SOF event cannot occur, because mask_ready=0 during a swap.
- **Arithmetic:** vid_hpos index and bit-select use shifts/masks (WORD_W is a power of 2); there is no multiplier.

Test Plan:
- Reset, then feed SOF + 19 words of line 0 (word k = 32'h0000_0001<<k), then pulse preload → disp_valid=1. During the next active line, foregnd_px=1 exactly at hpos=33*k one cycle later (k=0..19); 0 elsewhere and at hpos>=640.
- Source stalls after 12 words, then preload → underrun pulses once; the whole next line outputs 0. The following complete line displays correctly.
- Fill a complete bank (20 words) while holding mask_valid=1 → mask_ready drops to 0 after the 20th accept. It re-asserts the cycle after preload; mask_ready=0 during the preload cycle itself.
- After reset, present 3 words with mask_sof=0 → sync_err pulses 3 times and the words are not stored. A subsequent SOF word is accepted at index 0.
- Mid-frame (fill_line=100, fill_cnt=7), present mask_sof=1 → sync_err pulses; fill_cnt=1, fill_line=0. Reset asserted mid-line → foregnd_px=0 immediately, and disp_valid=0 until a full line is refilled.
